// File: rtl/display_pwr_seq.sv
// display_pwr_seq: orders PLL enable, lock settle, pixel-clock gate and pixel reset for the display path.
// Optional feature macro: DISP_SEQ_AUTO_RETRY_EN (automatic relock retries before entering ERROR).
module display_pwr_seq #(
  parameter int LOCK_TIMEOUT    = 1024,
  parameter int SETTLE_CYCLES   = 16,
  parameter int RST_HOLD_CYCLES = 8,
  parameter int CNT_W           = 16,
  parameter int MAX_RETRY       = 3
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       en_req,
  input  logic       err_clr,
  input  logic       clk_locked,
  output logic       pll_en,
  output logic       pix_clk_gate,
  output logic       pix_rst,
  output logic       disp_ready,
  output logic       seq_busy,
  output logic       err_timeout,
  output logic       err_lock_lost,
  output logic [2:0] seq_state,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PLL_WAIT = 3'd1,
    S_SETTLE   = 3'd2,
    S_CLK_ON   = 3'd3,
    S_RUN      = 3'd4,
    S_SHUTDOWN = 3'd5,
    S_ERROR    = 3'd7
  } state_t;

`ifdef DISP_SEQ_AUTO_RETRY_EN
  localparam bit AUTO_RETRY = 1'b1;
`else
  localparam bit AUTO_RETRY = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             relock, relock_nxt;
  logic             err_timeout_nxt, err_lock_lost_nxt;
  logic [1:0]       retry, retry_nxt, retry_base;
  logic             locked_meta, locked_s;

  // {pll_en, pix_clk_gate, pix_rst} for each state
  function automatic logic [2:0] path_outputs(input state_t s);
    case (s)
      S_PLL_WAIT, S_SETTLE: return 3'b101;
      S_CLK_ON, S_SHUTDOWN: return 3'b111;
      S_RUN:                return 3'b110;
      default:              return 3'b001;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= clk_locked;
      locked_s    <= locked_meta;
    end
  end

  // Next-state, counter, retry and sticky-flag logic; err_clr acts before any fault raised this cycle.
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    relock_nxt        = relock;
    retry_base        = err_clr ? 2'd0 : retry;
    retry_nxt         = retry_base;
    err_timeout_nxt   = err_clr ? 1'b0 : err_timeout;
    err_lock_lost_nxt = err_clr ? 1'b0 : err_lock_lost;
    case (state)
      S_OFF: begin
        cnt_nxt = CNT_ZERO;
        if (en_req && !err_timeout && !err_lock_lost) begin
          state_nxt = S_PLL_WAIT;
        end else begin
          state_nxt = S_OFF;
        end
      end
      S_PLL_WAIT: begin
        if (!en_req) begin
          state_nxt = S_SHUTDOWN; cnt_nxt = CNT_ZERO; relock_nxt = 1'b0;
        end else if (locked_s) begin
          state_nxt = S_SETTLE; cnt_nxt = CNT_ZERO;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_nxt = CNT_ZERO;
          if (AUTO_RETRY && (retry_base != RETRY_LIMIT)) begin
            state_nxt = S_SHUTDOWN; relock_nxt = 1'b1; retry_nxt = retry_base + 2'd1;
          end else begin
            state_nxt = S_ERROR; err_timeout_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      S_SETTLE: begin
        if (!en_req) begin
          state_nxt = S_SHUTDOWN; cnt_nxt = CNT_ZERO; relock_nxt = 1'b0;
        end else if (!locked_s) begin
          state_nxt = S_PLL_WAIT; cnt_nxt = CNT_ZERO;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = S_CLK_ON; cnt_nxt = CNT_ZERO;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      S_CLK_ON: begin
        if (!en_req) begin
          state_nxt = S_SHUTDOWN; cnt_nxt = CNT_ZERO; relock_nxt = 1'b0;
        end else if (!locked_s) begin
          state_nxt = S_SHUTDOWN; cnt_nxt = CNT_ZERO; relock_nxt = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = S_RUN; cnt_nxt = CNT_ZERO; retry_nxt = 2'd0;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      S_RUN: begin
        cnt_nxt = CNT_ZERO;
        if (!en_req) begin
          state_nxt = S_SHUTDOWN; relock_nxt = 1'b0;
        end else if (!locked_s) begin
          if (AUTO_RETRY && (retry_base != RETRY_LIMIT)) begin
            state_nxt = S_SHUTDOWN; relock_nxt = 1'b1; retry_nxt = retry_base + 2'd1;
          end else begin
            state_nxt = S_ERROR; err_lock_lost_nxt = 1'b1;
          end
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_SHUTDOWN: begin
        if (cnt == HOLD_LAST) begin
          state_nxt  = (relock && en_req) ? S_PLL_WAIT : S_OFF;
          cnt_nxt    = CNT_ZERO;
          relock_nxt = 1'b0;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      S_ERROR: begin
        cnt_nxt = CNT_ZERO;
        if (err_clr) begin
          state_nxt = S_OFF;
        end else begin
          state_nxt = S_ERROR;
        end
      end
      default: begin
        state_nxt = S_OFF; cnt_nxt = CNT_ZERO; relock_nxt = 1'b0;
      end
    endcase
  end

  // State, counters, sticky flags and Moore outputs registered from the next state.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state         <= S_OFF;
      cnt           <= CNT_ZERO;
      relock        <= 1'b0;
      retry         <= 2'd0;
      err_timeout   <= 1'b0;
      err_lock_lost <= 1'b0;
      pll_en        <= 1'b0;
      pix_clk_gate  <= 1'b0;
      pix_rst       <= 1'b1;
      disp_ready    <= 1'b0;
      seq_busy      <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      relock        <= relock_nxt;
      retry         <= retry_nxt;
      err_timeout   <= err_timeout_nxt;
      err_lock_lost <= err_lock_lost_nxt;
      {pll_en, pix_clk_gate, pix_rst} <= path_outputs(state_nxt);
      disp_ready    <= (state_nxt == S_RUN);
      seq_busy      <= state_nxt inside {S_PLL_WAIT, S_SETTLE, S_CLK_ON, S_SHUTDOWN};
    end
  end

  assign seq_state = state;
  assign retry_cnt = retry;

endmodule

// File: tb/tb_display_pwr_seq.sv
// Bench for display_pwr_seq: randomized episodes, phase/countdown reference model, scoreboard queue
// checked by an independent negedge monitor.
`timescale 1ns/1ps
module tb_display_pwr_seq;

  localparam int LOCK_TIMEOUT    = 1024;
  localparam int SETTLE_CYCLES   = 16;
  localparam int RST_HOLD_CYCLES = 8;
  localparam int MAX_RETRY       = 3;
`ifdef DISP_SEQ_AUTO_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif
  localparam int P_OFF = 0, P_WAIT = 1, P_SETTLE = 2, P_CLKON = 3, P_RUN = 4, P_SHUT = 5, P_ERR = 7;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1, en_req = 1'b0, err_clr = 1'b0, clk_locked = 1'b0;
  logic       pll_en, pix_clk_gate, pix_rst, disp_ready, seq_busy, err_timeout, err_lock_lost;
  logic [2:0] seq_state;
  logic [1:0] retry_cnt;

  display_pwr_seq dut (
    .clk_sys(clk_sys), .rst(rst), .en_req(en_req), .err_clr(err_clr), .clk_locked(clk_locked),
    .pll_en(pll_en), .pix_clk_gate(pix_clk_gate), .pix_rst(pix_rst), .disp_ready(disp_ready),
    .seq_busy(seq_busy), .err_timeout(err_timeout), .err_lock_lost(err_lock_lost),
    .seq_state(seq_state), .retry_cnt(retry_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: current phase, cycles left in it, and the lock as seen through two flops.
  int  ph, left, retries;
  bit  relock, e_to, e_ll, sync_m, sync_s;
  logic [12:0] exp_q[$];
  int  checks = 0, errors = 0;

  function automatic int dur(input int p);
    case (p)
      P_WAIT:          return LOCK_TIMEOUT;
      P_SETTLE:        return SETTLE_CYCLES;
      P_CLKON, P_SHUT: return RST_HOLD_CYCLES;
      default:         return 0;
    endcase
  endfunction

  task automatic enter(input int p);
    ph = p; left = dur(p);
  endtask

  task automatic shutdown(input bit rl);
    enter(P_SHUT); relock = rl;
  endtask

  task automatic fault(input bit is_timeout);
    if (RETRY_ON && retries < MAX_RETRY) begin
      retries++; shutdown(1'b1);
    end else begin
      if (is_timeout) e_to = 1'b1; else e_ll = 1'b1;
      enter(P_ERR);
    end
  endtask

  task automatic model_reset();
    ph = P_OFF; left = 0; retries = 0; relock = 1'b0;
    e_to = 1'b0; e_ll = 1'b0; sync_m = 1'b0; sync_s = 1'b0;
  endtask

  task automatic model_step();
    bit ls;
    ls = sync_s; sync_s = sync_m; sync_m = clk_locked;
    if (err_clr) begin e_to = 1'b0; e_ll = 1'b0; retries = 0; end
    case (ph)
      P_OFF:    if (en_req && !e_to && !e_ll) enter(P_WAIT);
      P_WAIT:   if (!en_req) shutdown(1'b0);
                else if (ls) enter(P_SETTLE);
                else begin left--; if (left == 0) fault(1'b1); end
      P_SETTLE: if (!en_req) shutdown(1'b0);
                else if (!ls) enter(P_WAIT);
                else begin left--; if (left == 0) enter(P_CLKON); end
      P_CLKON:  if (!en_req) shutdown(1'b0);
                else if (!ls) shutdown(1'b1);
                else begin left--; if (left == 0) begin enter(P_RUN); retries = 0; end end
      P_RUN:    if (!en_req) shutdown(1'b0);
                else if (!ls) fault(1'b0);
      P_SHUT:   begin
                  left--;
                  if (left == 0) begin
                    if (relock && en_req) enter(P_WAIT); else enter(P_OFF);
                    relock = 1'b0;
                  end
                end
      P_ERR:    if (err_clr) enter(P_OFF);
      default:  enter(P_OFF);
    endcase
  endtask

  function automatic logic [12:0] expect_vec();
    logic [2:0] path;
    case (ph)
      P_WAIT, P_SETTLE: path = 3'b101;
      P_CLKON, P_SHUT:  path = 3'b111;
      P_RUN:            path = 3'b110;
      default:          path = 3'b001;
    endcase
    return {3'(ph), path, (ph == P_RUN), (ph inside {P_WAIT, P_SETTLE, P_CLKON, P_SHUT}),
            e_to, e_ll, 2'(retries)};
  endfunction

  task automatic tick();
    @(posedge clk_sys); #1;
    if (rst) model_reset(); else model_step();
    exp_q.push_back(expect_vec());
  endtask

  // Asynchronous reset lands mid-cycle: this cycle's expectation becomes the reset vector.
  task automatic pulse_rst();
    rst = 1'b1; model_reset();
    void'(exp_q.pop_back());
    exp_q.push_back(expect_vec());
    tick();
    rst = 1'b0;
  endtask

  task automatic check_int(input string tag, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, expv);
    end
  endtask

  task automatic wait_phase(input int p, input int budget, input string tag, output int n);
    n = 0;
    while (ph != p && n < budget) begin tick(); n++; end
    check_int(tag, ph, p);
  endtask

  task automatic go_idle();
    int n;
    en_req = 1'b0; clk_locked = 1'b1;
    if (ph == P_ERR) begin err_clr = 1'b1; tick(); err_clr = 1'b0; end
    wait_phase(P_OFF, 40, "idle_reach_off", n);
    repeat (3) tick();
  endtask

  // Monitor: compares every presented output vector against the queued expectation.
  initial begin
    logic [12:0] exp_v, act_v;
    forever begin
      @(negedge clk_sys);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {seq_state, pll_en, pix_clk_gate, pix_rst, disp_ready, seq_busy,
                 err_timeout, err_lock_lost, retry_cnt};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          if (errors <= 20)
            $display("FAIL outputs @%0t: got state=%0d pll/gate/rst=%b ready/busy=%b err=%b retry=%0d, expected state=%0d pll/gate/rst=%b ready/busy=%b err=%b retry=%0d",
                     $time, act_v[12:10], act_v[9:7], act_v[6:5], act_v[4:3], act_v[1:0],
                     exp_v[12:10], exp_v[9:7], exp_v[6:5], exp_v[4:3], exp_v[1:0]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, kind;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    go_idle();
    for (int ep = 0; ep < 30; ep++) begin
      kind = (ep < 9) ? ep : $urandom_range(3, 8);
      go_idle();
      case (kind)
        0: begin // normal power-up, run, orderly power-down
          en_req = 1'b1;
          wait_phase(P_RUN, 40, "rise_reach_run", n);
          check_int("rise_to_run_cycles", n, 2 + SETTLE_CYCLES + RST_HOLD_CYCLES);
          repeat ($urandom_range(1, 15)) tick();
          err_clr = 1'b1; tick(); err_clr = 1'b0;
          repeat ($urandom_range(1, 5)) tick();
          en_req = 1'b0;
          wait_phase(P_OFF, 20, "drop_reach_off", n);
          check_int("shutdown_cycles", n, 1 + RST_HOLD_CYCLES);
        end
        1: begin // lock never arrives
          clk_locked = 1'b0;
          repeat (3) tick();
          en_req = 1'b1;
          wait_phase(P_ERR, 5000, "timeout_reach_err", n);
          check_int("timeout_cycles", n,
                    1 + LOCK_TIMEOUT + (RETRY_ON ? MAX_RETRY * (RST_HOLD_CYCLES + LOCK_TIMEOUT) : 0));
          repeat ($urandom_range(1, 5)) tick();
          en_req = 1'($urandom_range(0, 1));
          err_clr = 1'b1; tick(); err_clr = 1'b0;
          repeat (4) tick();
        end
        2: begin // lock lost while running
          en_req = 1'b1;
          wait_phase(P_RUN, 40, "ll_reach_run", n);
          repeat ($urandom_range(1, 10)) tick();
          clk_locked = 1'b0;
          wait_phase(P_ERR, 5000, "ll_reach_err", n);
          clk_locked = 1'b1;
          repeat (3) tick();
          en_req = 1'($urandom_range(0, 1));
          err_clr = 1'b1; tick(); err_clr = 1'b0;
          repeat (5) tick();
        end
        3: begin // en_req drop coincides with lock loss seen in RUN
          en_req = 1'b1;
          wait_phase(P_RUN, 40, "sim_reach_run", n);
          repeat ($urandom_range(1, 6)) tick();
          clk_locked = 1'b0;
          tick(); tick();
          en_req = 1'b0;
          wait_phase(P_OFF, 20, "sim_reach_off", n);
          check_int("sim_cycles_to_off", n, 1 + RST_HOLD_CYCLES);
        end
        4: begin // one-cycle lock glitch mid-SETTLE
          en_req = 1'b1;
          wait_phase(P_SETTLE, 10, "gl_reach_settle", n);
          repeat ($urandom_range(0, 10)) tick();
          clk_locked = 1'b0; tick(); clk_locked = 1'b1;
          wait_phase(P_WAIT, 10, "gl_back_to_wait", n);
          wait_phase(P_SETTLE, 10, "gl_relock", n);
          wait_phase(P_RUN, 40, "gl_reach_run", n);
          check_int("relock_to_run_cycles", n, SETTLE_CYCLES + RST_HOLD_CYCLES);
        end
        5: begin // asynchronous reset mid-SETTLE
          en_req = 1'b1;
          wait_phase(P_SETTLE, 10, "rst_reach_settle", n);
          repeat ($urandom_range(1, 8)) tick();
          pulse_rst();
          repeat (3) tick();
        end
        6: begin // random input activity
          repeat (80) begin
            en_req     = ($urandom_range(0, 9) < 7);
            clk_locked = ($urandom_range(0, 19) != 0);
            err_clr    = ($urandom_range(0, 29) == 0);
            tick();
          end
          err_clr = 1'b0;
        end
        7: begin // lock glitch in CLK_ON forces a relock through SHUTDOWN
          en_req = 1'b1;
          wait_phase(P_CLKON, 40, "co_reach_clkon", n);
          repeat ($urandom_range(0, 3)) tick();
          clk_locked = 1'b0; tick(); clk_locked = 1'b1;
          wait_phase(P_SHUT, 10, "co_reach_shut", n);
          wait_phase(P_RUN, 80, "co_reach_run", n);
        end
        default: begin // request withdrawn in PLL_WAIT, re-raised during SHUTDOWN
          clk_locked = 1'b0;
          repeat (3) tick();
          en_req = 1'b1;
          repeat ($urandom_range(2, 50)) tick();
          en_req = 1'b0; tick(); tick();
          en_req = 1'b1;
          wait_phase(P_OFF, 20, "pw_reach_off", n);
        end
      endcase
    end
    go_idle();
    @(negedge clk_sys); @(negedge clk_sys);
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
